// File: rtl/ram_32768x3.sv
// ram_32768x3: 32768 x 3 single-port synchronous RAM holding the arena colour map.
// Ports: clock, resetn (async, active-low), address {x[7:0],y[6:0]}, data, wren in;
//        q (registered read data, write-through), ready (clear sweep done) out.
module ram_32768x3 #(
    parameter int                    ADDR_WIDTH     = 15,
    parameter int                    DATA_WIDTH     = 3,
    parameter bit                    CLEAR_ON_RESET = 1'b1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE     = '0
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  wren,
    output logic [DATA_WIDTH-1:0] q,
    output logic                  ready
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Extra top bit marks "every address swept".
    logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
    logic                  ready_q, ready_d;
    logic                  rd_vld_q, rd_vld_d;
    logic [DATA_WIDTH-1:0] rd_q;

    logic                  sweep;
    logic                  user_we;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;

    always_comb begin
        sweep     = CLEAR_ON_RESET && !ready_q && !cnt_q[ADDR_WIDTH];
        user_we   = ready_q && wren;
        // One write port shared by the sweep and the user.
        mem_we    = sweep || user_we;
        mem_addr  = sweep ? cnt_q[ADDR_WIDTH-1:0] : address;
        mem_wdata = sweep ? INIT_VALUE : data;
        cnt_d     = sweep ? cnt_q + CNT_ONE : cnt_q;
        // Ready one edge after the last sweep write (or after reset if no sweep).
        ready_d   = ready_q || !CLEAR_ON_RESET || cnt_q[ADDR_WIDTH];
        // q is only exposed for reads launched while ready was already high.
        rd_vld_d  = ready_q;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cnt_q    <= '0;
            ready_q  <= 1'b0;
            rd_vld_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            ready_q  <= ready_d;
            rd_vld_q <= rd_vld_d;
        end
    end

    // Storage and read register carry no reset so they map onto block RAM.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
        rd_q <= mem_we ? mem_wdata : mem[mem_addr];
    end

    assign q     = rd_vld_q ? rd_q : '0;
    assign ready = ready_q;

endmodule

// File: tb/tb_ram_32768x3.sv
// tb_ram_32768x3: directed scoreboard bench for ram_32768x3.
// Covers sweep timing, async reset, read/write, write-through and no-sweep mode.
module tb_ram_32768x3;

    logic        clk = 1'b0;
    logic        rstn, rstn0;
    logic [14:0] addr, addr0;
    logic [2:0]  din, din0;
    logic        we, we0;
    logic [2:0]  q, q0;
    logic        rdy, rdy0;

    typedef struct {
        string      tag;
        logic [2:0] exp;
    } exp_t;

    exp_t       sbq[$];
    int         checks = 0;
    int         passed = 0;
    int         cyc;
    int         rise;
    logic [2:0] pre [4];

    always #5 clk = ~clk;

    ram_32768x3 dut (
        .clock(clk), .resetn(rstn), .address(addr), .data(din),
        .wren(we), .q(q), .ready(rdy)
    );

    ram_32768x3 #(.CLEAR_ON_RESET(1'b0)) dut0 (
        .clock(clk), .resetn(rstn0), .address(addr0), .data(din0),
        .wren(we0), .q(q0), .ready(rdy0)
    );

    task automatic chk(string tag, logic [2:0] obs, logic [2:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_int(string tag, int obs, int exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Drive one port cycle at a negedge, push the expected q, pop after the edge.
    task automatic op(bit u, string tag, logic [14:0] a, logic [2:0] d,
                      logic w, logic [2:0] e);
        exp_t item;
        if (u) begin
            addr0 = a; din0 = d; we0 = w;
        end else begin
            addr = a; din = d; we = w;
        end
        sbq.push_back('{tag, e});
        @(negedge clk);
        item = sbq.pop_front();
        chk(item.tag, u ? q0 : q, item.exp);
        we = 1'b0;
        we0 = 1'b0;
    endtask

    // Count edges after release until ready; returns 0 if the bound expires.
    task automatic wait_ready(output int n);
        n = 0;
        for (int i = 1; i <= 40000; i++) begin
            @(posedge clk);
            #1;
            if (i == 100) begin
                addr = 15'h0005; din = 3'b111; we = 1'b1;
            end
            if (i == 101) begin
                we = 1'b0;
                chk("q_zero_in_sweep", q, 3'b000);
            end
            if (rdy) begin
                n = i;
                break;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        rstn = 1'b0; rstn0 = 1'b0;
        addr = '0; din = '0; we = 1'b0;
        addr0 = '0; din0 = '0; we0 = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_ready", {2'b0, rdy}, 3'b000);
        chk("rst_q", q, 3'b000);

        // Reset in the middle of the first sweep.
        @(negedge clk);
        rstn = 1'b1;
        repeat (1000) @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        chk("mid_rst_ready", {2'b0, rdy}, 3'b000);
        chk("mid_rst_q", q, 3'b000);
        @(negedge clk);
        rstn = 1'b1;
        wait_ready(rise);
        chk_int("sweep_len_1", rise, 32769);

        op(0, "ignored_wr_0005", 15'h0005, 3'b000, 1'b0, 3'b000);

        // Boundary addresses on a freshly cleared arena.
        op(0, "wr_0000", 15'h0000, 3'b100, 1'b1, 3'b100);
        op(0, "wr_7fff", 15'h7FFF, 3'b011, 1'b1, 3'b011);
        op(0, "rd_0000", 15'h0000, 3'b000, 1'b0, 3'b100);
        op(0, "rd_7fff", 15'h7FFF, 3'b000, 1'b0, 3'b011);
        op(0, "rd_0001", 15'h0001, 3'b000, 1'b0, 3'b000);
        op(0, "rd_7ffe", 15'h7FFE, 3'b000, 1'b0, 3'b000);

        // Write then read.
        op(0, "wr_4f77", 15'h4F77, 3'b001, 1'b1, 3'b001);
        op(0, "wr_0001", 15'h0001, 3'b110, 1'b1, 3'b110);
        op(0, "rd_4f77", 15'h4F77, 3'b000, 1'b0, 3'b001);
        op(0, "rd_0001b", 15'h0001, 3'b000, 1'b0, 3'b110);

        // Read-during-write.
        op(0, "wr_1234_a", 15'h1234, 3'b010, 1'b1, 3'b010);
        op(0, "rd_1234_a", 15'h1234, 3'b000, 1'b0, 3'b010);
        op(0, "rdw_1234", 15'h1234, 3'b111, 1'b1, 3'b111);
        op(0, "nowr_1234", 15'h1234, 3'b101, 1'b0, 3'b111);
        op(0, "rd_1234_b", 15'h1234, 3'b000, 1'b0, 3'b111);

        // Preload nonzero data, then reset and sweep again.
        for (int i = 0; i < 4; i++) pre[i] = 3'($urandom_range(1, 7));
        op(0, "pre_0000", 15'h0000, pre[0], 1'b1, pre[0]);
        op(0, "pre_0001", 15'h0001, pre[1], 1'b1, pre[1]);
        op(0, "pre_7fff", 15'h7FFF, pre[3], 1'b1, pre[3]);
        op(0, "pre_4000", 15'h4000, pre[2], 1'b1, pre[2]);
        #2;
        rstn = 1'b0;
        #1;
        chk("async_rst_q", q, 3'b000);
        chk("async_rst_ready", {2'b0, rdy}, 3'b000);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        wait_ready(rise);
        chk_int("sweep_len_2", rise, 32769);
        op(0, "clr_0000", 15'h0000, 3'b000, 1'b0, 3'b000);
        op(0, "clr_0001", 15'h0001, 3'b000, 1'b0, 3'b000);
        op(0, "clr_4000", 15'h4000, 3'b000, 1'b0, 3'b000);
        op(0, "clr_7fff", 15'h7FFF, 3'b000, 1'b0, 3'b000);

        // No-sweep instance.
        rstn0 = 1'b1;
        #1;
        chk("ns_ready_pre", {2'b0, rdy0}, 3'b000);
        @(negedge clk);
        chk("ns_ready_1", {2'b0, rdy0}, 3'b001);
        op(1, "ns_wr_0abc", 15'h0ABC, 3'b101, 1'b1, 3'b101);
        op(1, "ns_rd_0abc", 15'h0ABC, 3'b000, 1'b0, 3'b101);
        #2;
        rstn0 = 1'b0;
        @(negedge clk);
        rstn0 = 1'b1;
        @(negedge clk);
        chk("ns_ready_2", {2'b0, rdy0}, 3'b001);
        op(1, "ns_keep_0abc", 15'h0ABC, 3'b000, 1'b0, 3'b101);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
